// File: rtl/iter_exec_unit_if.sv
// ---------------------------------------------------------------------------
// iter_exec_unit_if
//   Request/response handshake bundle for the iterative execute unit.
//   Ports (signals):
//     in_valid  / in_ready   request handshake (op, a, b qualified by in_valid)
//     op        5-bit operation code
//     a, b      WIDTH-bit operands (rs1, rs2/immediate)
//     out_valid / out_ready  result handshake
//     result    WIDTH-bit result
//     illegal   op code not recognised, qualified by out_valid
//   Modports: master = pipeline side, slave = execute unit.
// ---------------------------------------------------------------------------
interface iter_exec_unit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             illegal;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, illegal
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, illegal
    );
endinterface

// File: rtl/iter_exec_unit.sv
// ---------------------------------------------------------------------------
// iter_exec_unit
//   RV32I ALU ops (1-cycle) plus RV32M multiply/divide (WIDTH-step shift-add
//   and restoring divide) behind valid/ready handshakes.
//   Ports:
//     clk_i    clock, all state on rising edge
//     rst_i    synchronous active-high reset (priority over flush_i)
//     flush_i  abandon any in-flight op, drop pending result, block accept
//     bus      iter_exec_unit_if.slave (request, response, illegal flag)
//
//   state  | meaning
//   IDLE   | in_ready=1, waiting for a request
//   BUSY   | mul/div iterating, one bit per cycle for WIDTH cycles
//   DONE   | out_valid=1, result held until out_ready
// ---------------------------------------------------------------------------
module iter_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    iter_exec_unit_if.slave       bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_AND    = 5'd2;
    localparam logic [4:0] OP_OR     = 5'd3;
    localparam logic [4:0] OP_XOR    = 5'd4;
    localparam logic [4:0] OP_SLT    = 5'd5;
    localparam logic [4:0] OP_SLTU   = 5'd6;
    localparam logic [4:0] OP_SLL    = 5'd7;
    localparam logic [4:0] OP_SRL    = 5'd8;
    localparam logic [4:0] OP_SRA    = 5'd9;
    localparam logic [4:0] OP_MUL    = 5'd16;
    localparam logic [4:0] OP_MULH   = 5'd17;
    localparam logic [4:0] OP_MULHSU = 5'd18;
    localparam logic [4:0] OP_DIV    = 5'd20;
    localparam logic [4:0] OP_REM    = 5'd22;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [4:0]         op_q, op_d;
    logic               neg_q, neg_d;     // negate product / quotient
    logic               rneg_q, rneg_d;   // negate remainder (dividend sign)
    logic [WIDTH-1:0]   mag_q, mag_d;     // |a| for mul, |b| for div
    logic [2*WIDTH-1:0] acc_q, acc_d;     // {hi, lo}: product or {remainder, quotient}
    logic [WIDTH-1:0]   result_q, result_d;
    logic               illegal_q, illegal_d;

    // Request decode
    logic               is_mul, is_div, is_alu, a_sgn, b_sgn, a_neg, b_neg;
    logic               div_zero, div_ovf;
    logic [WIDTH-1:0]   a_mag, b_mag, alu_res, spec_res;

    always_comb begin
        is_mul   = (bus.op[4:2] == 3'b100);
        is_div   = (bus.op[4:2] == 3'b101);
        is_alu   = (bus.op <= OP_SRA);
        a_sgn    = (bus.op == OP_MULH) || (bus.op == OP_MULHSU) ||
                   (bus.op == OP_DIV)  || (bus.op == OP_REM);
        b_sgn    = (bus.op == OP_MULH) || (bus.op == OP_DIV) || (bus.op == OP_REM);
        a_neg    = a_sgn & bus.a[WIDTH-1];
        b_neg    = b_sgn & bus.b[WIDTH-1];
        a_mag    = a_neg ? -bus.a : bus.a;
        b_mag    = b_neg ? -bus.b : bus.b;
        div_zero = is_div && (bus.b == '0);
        div_ovf  = ((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
                   (bus.a == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.b == '1);
        // op[1] distinguishes REM/REMU from DIV/DIVU
        if (div_zero)
            spec_res = bus.op[1] ? bus.a : '1;
        else
            spec_res = bus.op[1] ? '0 : bus.a;
    end

    always_comb begin
        alu_res = '0;
        case (bus.op)
            OP_ADD:  alu_res = bus.a + bus.b;
            OP_SUB:  alu_res = bus.a - bus.b;
            OP_AND:  alu_res = bus.a & bus.b;
            OP_OR:   alu_res = bus.a | bus.b;
            OP_XOR:  alu_res = bus.a ^ bus.b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            OP_SLL:  alu_res = bus.a << bus.b[CW-1:0];
            OP_SRL:  alu_res = bus.a >> bus.b[CW-1:0];
            OP_SRA:  alu_res = WIDTH'($signed(bus.a) >>> bus.b[CW-1:0]);
            default: alu_res = '0;
        endcase
    end

    // One iteration step of multiply / divide
    logic [WIDTH:0]     mul_sum, div_sh, div_diff;
    logic [2*WIDTH-1:0] acc_step, prod;
    logic [WIDTH-1:0]   quot, rem, mul_res, div_res;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_q} : '0);
        div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff = div_sh - {1'b0, mag_q};
        if (op_q[2])
            acc_step = div_diff[WIDTH] ? {div_sh[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b0}
                                       : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else
            acc_step = {mul_sum, acc_q[WIDTH-1:1]};

        prod    = neg_q ? -acc_step : acc_step;
        mul_res = (op_q == OP_MUL) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
        quot    = acc_step[WIDTH-1:0];
        rem     = acc_step[2*WIDTH-1:WIDTH];
        div_res = op_q[1] ? (rneg_q ? -rem : rem) : (neg_q ? -quot : quot);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        neg_d     = neg_q;
        rneg_d    = rneg_q;
        mag_d     = mag_q;
        acc_d     = acc_q;
        result_d  = result_q;
        illegal_d = illegal_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid && !flush_i) begin
                    op_d = bus.op;
                    if ((is_mul || is_div) && !div_zero && !div_ovf) begin
                        mag_d   = is_mul ? a_mag : b_mag;
                        acc_d   = {{WIDTH{1'b0}}, (is_mul ? b_mag : a_mag)};
                        neg_d   = a_neg ^ b_neg;
                        rneg_d  = a_neg;
                        cnt_d   = '0;
                        state_d = S_BUSY;
                    end else begin
                        result_d  = (div_zero || div_ovf) ? spec_res : alu_res;
                        illegal_d = !(is_alu || is_mul || is_div);
                        state_d   = S_DONE;
                    end
                end
            end
            S_BUSY: begin
                acc_d = acc_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH-1)) begin
                    result_d  = op_q[2] ? div_res : mul_res;
                    illegal_d = 1'b0;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (flush_i)
            state_d = S_IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
            mag_q     <= '0;
            acc_q     <= '0;
            result_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
            rneg_q    <= rneg_d;
            mag_q     <= mag_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.result    = result_q;
    assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_iter_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_iter_exec_unit
//   Directed and random checks of iter_exec_unit at WIDTH=32. Expected
//   result/illegal/latency are pushed to a scoreboard when a request is
//   driven and popped when the unit presents out_valid.
// ---------------------------------------------------------------------------
module tb_iter_exec_unit;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0] res;
        logic         ill;
        int           lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    iter_exec_unit_if #(.WIDTH(W)) bus ();

    iter_exec_unit #(.WIDTH(W)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        n_assert++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        longint      sa, sb_v, ub, q;
        logic [63:0] p;
        logic signed [W-1:0] as_v;
        sa   = longint'($signed(a));
        sb_v = longint'($signed(b));
        ub   = {32'b0, b};
        as_v = a;
        e.ill = 1'b0;
        e.lat = 1;
        e.res = '0;
        case (op)
            5'd0:  e.res = a + b;
            5'd1:  e.res = a - b;
            5'd2:  e.res = a & b;
            5'd3:  e.res = a | b;
            5'd4:  e.res = a ^ b;
            5'd5:  e.res = (sa < sb_v) ? 32'd1 : 32'd0;
            5'd6:  e.res = (a < b) ? 32'd1 : 32'd0;
            5'd7:  e.res = a << b[4:0];
            5'd8:  e.res = a >> b[4:0];
            5'd9:  e.res = W'(as_v >>> b[4:0]);
            5'd16: begin p = {32'b0, a} * {32'b0, b}; e.res = p[31:0];  e.lat = W + 1; end
            5'd17: begin p = sa * sb_v;               e.res = p[63:32]; e.lat = W + 1; end
            5'd18: begin p = sa * ub;                 e.res = p[63:32]; e.lat = W + 1; end
            5'd19: begin p = {32'b0, a} * {32'b0, b}; e.res = p[63:32]; e.lat = W + 1; end
            5'd20, 5'd22: begin
                if (b == 0) e.res = (op == 5'd20) ? 32'hFFFF_FFFF : a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    e.res = (op == 5'd20) ? 32'h8000_0000 : 32'h0;
                else begin
                    q = (op == 5'd20) ? (sa / sb_v) : (sa % sb_v);
                    e.res = q[31:0];
                    e.lat = W + 1;
                end
            end
            5'd21, 5'd23: begin
                if (b == 0) e.res = (op == 5'd21) ? 32'hFFFF_FFFF : a;
                else begin
                    e.res = (op == 5'd21) ? (a / b) : (a % b);
                    e.lat = W + 1;
                end
            end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    // Drive one request (unit assumed IDLE), wait for the response and compare
    task automatic execute(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input string tag);
        exp_t e;
        int   lat;
        bus.op = op; bus.a = a; bus.b = b; bus.in_valid = 1'b1;
        check({tag, "_in_ready"}, W'(bus.in_ready), W'(1));
        tick();
        bus.in_valid = 1'b0;
        bus.op = 5'($urandom); bus.a = $urandom; bus.b = $urandom;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
        e = sb.pop_front();
        check({tag, "_latency"}, W'(lat), W'(e.lat));
        check({tag, "_result"}, bus.result, e.res);
        check({tag, "_illegal"}, W'(bus.illegal), W'(e.ill));
        tick();
    endtask

    task automatic run_model(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                             input string tag);
        sb.push_back(model(op, a, b));
        execute(op, a, b, tag);
    endtask

    task automatic run_exp(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] res, input logic ill, input int lat, input string tag);
        exp_t e;
        e.res = res; e.ill = ill; e.lat = lat;
        sb.push_back(e);
        execute(op, a, b, tag);
    endtask

    initial begin
        logic [W-1:0] held;
        int           seen;
        logic [4:0]   rop;
        logic [W-1:0] ra, rb;

        rst = 1'b1; flush = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.op = '0; bus.a = '0; bus.b = '0;
        tick(); tick();
        check("rst_in_ready",  W'(bus.in_ready),  W'(1));
        check("rst_out_valid", W'(bus.out_valid), W'(0));
        check("rst_result",    bus.result,        '0);
        check("rst_illegal",   W'(bus.illegal),   W'(0));
        rst = 1'b0;
        tick();

        // ALU
        run_exp(5'd0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1, "add_ovf");
        run_exp(5'd1, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1, "sub");
        run_exp(5'd9, 32'h8000_0010, 32'd4, 32'hF800_0001, 1'b0, 1, "sra");
        run_exp(5'd8, 32'h8000_0010, 32'd4, 32'h0800_0001, 1'b0, 1, "srl");
        run_exp(5'd7, 32'h1234_5678, 32'd32, 32'h1234_5678, 1'b0, 1, "sll_by0");
        run_exp(5'd5, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1, "slt");
        run_exp(5'd6, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1, "sltu");

        // Multiply
        run_exp(5'd16, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 1'b0, 33, "mul");
        run_exp(5'd19, 32'hFFFF_FFFF, 32'd3, 32'h0000_0002, 1'b0, 33, "mulhu");
        run_exp(5'd17, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFF, 1'b0, 33, "mulh");
        run_exp(5'd18, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33, "mulhsu");

        // Divide
        run_exp(5'd20, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33, "div_neg");
        run_exp(5'd22, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 33, "rem_neg");
        run_exp(5'd21, 32'd100, 32'd7, 32'd14, 1'b0, 33, "divu");
        run_exp(5'd23, 32'd100, 32'd7, 32'd2, 1'b0, 33, "remu");
        run_exp(5'd20, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1'b0, 1, "div_by0");
        run_exp(5'd22, 32'h1234_5678, 32'd0, 32'h1234_5678, 1'b0, 1, "rem_by0");
        run_exp(5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1, "div_ovf");
        run_exp(5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0, 1, "rem_ovf");
        run_exp(5'd21, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0, 33, "divu_no_ovf");

        // Illegal op
        run_exp(5'd31, 32'h1, 32'h2, 32'h0, 1'b1, 1, "illegal");

        // Back-pressure: result held while out_ready low
        bus.op = 5'd16; bus.a = 32'd5; bus.b = 32'd7; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        seen = 0;
        while (bus.out_valid !== 1'b1 && seen < 100) begin tick(); seen++; end
        check("hold_reached", W'(bus.out_valid), W'(1));
        check("hold_result",  bus.result, 32'd35);
        held = bus.result;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_out_valid", W'(bus.out_valid), W'(1));
            check("hold_in_ready",  W'(bus.in_ready),  W'(0));
            check("hold_stable",    bus.result,        held);
        end
        bus.out_ready = 1'b1;
        tick();
        check("release_out_valid", W'(bus.out_valid), W'(0));
        check("release_in_ready",  W'(bus.in_ready),  W'(1));

        // Flush mid-BUSY
        bus.op = 5'd16; bus.a = 32'd9; bus.b = 32'd9; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (10) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_out_valid", W'(bus.out_valid), W'(0));
        check("flush_in_ready",  W'(bus.in_ready),  W'(1));
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.out_valid === 1'b1) seen++;
        end
        check("flush_no_stale", W'(seen), W'(0));
        run_exp(5'd0, 32'd2, 32'd3, 32'd5, 1'b0, 1, "add_after_flush");

        // Reset mid-BUSY
        bus.op = 5'd20; bus.a = 32'd1000; bus.b = 32'd3; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_busy_out_valid", W'(bus.out_valid), W'(0));
        check("rst_busy_in_ready",  W'(bus.in_ready),  W'(1));
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.out_valid === 1'b1) seen++;
        end
        check("rst_no_stale", W'(seen), W'(0));
        run_exp(5'd0, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b0, 1, "add_after_rst");

        // Flush suppresses a same-cycle accept
        bus.op = 5'd0; bus.a = 32'd1; bus.b = 32'd1; bus.in_valid = 1'b1; flush = 1'b1;
        tick();
        bus.in_valid = 1'b0; flush = 1'b0;
        check("flush_accept_out_valid", W'(bus.out_valid), W'(0));
        check("flush_accept_in_ready",  W'(bus.in_ready),  W'(1));

        // Flush drops a pending result in DONE
        bus.op = 5'd0; bus.a = 32'd1; bus.b = 32'd1; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        check("done_before_flush", W'(bus.out_valid), W'(1));
        flush = 1'b1;
        tick();
        flush = 1'b0; bus.out_ready = 1'b1;
        check("done_flush_out_valid", W'(bus.out_valid), W'(0));

        // Random mix against the reference model
        for (int i = 0; i < 24; i++) begin
            rop = 5'($urandom_range(0, 23));
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            run_model(rop, ra, rb, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
